dmem_port_arbiter: RTL and testbench

Two-requester front end for the core's word-addressed data RAM. It shares the single RAM port between the LSU (port 0) and a debug/loader master (port 1), arbitrating round-robin by default. It also converts sub-word stores into a read-modify-write sequence, because the RAM writes whole words whenever any select bit is set. The block sits between the LSU/debug masters and the data RAM, and owns every RAM control signal.

---
 rtl/dmem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-master front end for the word-addressed data RAM: round-robin or fixed
// priority arbitration, plus read-modify-write expansion of sub-word stores.

module dmem_port_rsp #(
  parameter logic PORT_ID = 1'b0
) (
  input  logic        rsp_vld,
  input  logic        rsp_port,
  input  logic [31:0] rsp_data,
  output logic        rvalid,
  output logic [31:0] rdata
);
  assign rvalid = rsp_vld && (rsp_port == PORT_ID);
  assign rdata  = rvalid ? rsp_data : 32'h0;
endmodule

module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_be_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_be_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              busy_o
);
  localparam int NUM_PORTS = 2;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } dmem_req_t;

  dmem_req_t [NUM_PORTS-1:0]        mreq;
  logic      [NUM_PORTS-1:0]        req;
  logic      [NUM_PORTS-1:0]        gnt;
  logic      [NUM_PORTS-1:0]        rvalid;
  logic      [NUM_PORTS-1:0][31:0]  rdata;

  logic [0:0]        state_q;
  logic              last_q;
  logic              rsp_vld_q, rsp_port_q;
  logic [31:0]       rsp_data_q;
  logic [ADDR_W-1:0] rmw_addr_q;
  logic [31:0]       rmw_word_q;
  logic              rmw_port_q;

  logic              sel, gnt_vld;
  logic              is_load, is_full, is_null, is_part;
  dmem_req_t         g;
  logic [31:0]       merged;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  assign req     = {m1_req_i, m0_req_i};
  assign mreq[0] = '{we: m0_we_i, be: m0_be_i,
                     addr: {m0_addr_i[ADDR_W-1:2], 2'b00}, wdata: m0_wdata_i};
  assign mreq[1] = '{we: m1_we_i, be: m1_be_i,
                     addr: {m1_addr_i[ADDR_W-1:2], 2'b00}, wdata: m1_wdata_i};

  // Tie goes to the port not granted last (or always port 0 in fixed mode).
  always_comb begin
    sel = req[1];
    if (&req) sel = FIXED_PRIO ? 1'b0 : ~last_q;
  end

  // Reset gating keeps grants (and hence RAM controls) low while in reset.
  assign gnt_vld = rst_ni && (state_q == IDLE) && (|req);
  assign gnt     = gnt_vld ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign g       = mreq[sel];

  assign is_load = !g.we;
  assign is_full = g.we && (g.be == 4'hf);
  assign is_null = g.we && (g.be == 4'h0);
  assign is_part = g.we && !is_full && !is_null;

  always_comb begin
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = g.be[i] ? g.wdata[8*i +: 8] : ram_rdata_i[8*i +: 8];
  end

  always_comb begin
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = 32'h0;
    if (state_q == RMW_WR) begin
      ram_ce_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_addr_o  = rmw_addr_q;
      ram_wdata_o = rmw_word_q;
    end else if (gnt_vld && !is_null) begin
      // Partial stores read here and write the merged word next cycle.
      ram_ce_o    = 1'b1;
      ram_we_o    = is_full;
      ram_addr_o  = g.addr;
      ram_wdata_o = is_full ? g.wdata : 32'h0;
    end
  end

  assign ram_sel_o = {4{ram_ce_o}};
  assign busy_o    = (state_q == RMW_WR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= 1'b0;
      rsp_data_q <= 32'h0;
      rmw_addr_q <= '0;
      rmw_word_q <= 32'h0;
      rmw_port_q <= 1'b0;
    end else begin
      rsp_vld_q <= 1'b0;
      if (state_q == RMW_WR) begin
        state_q    <= IDLE;
        rsp_vld_q  <= 1'b1;
        rsp_port_q <= rmw_port_q;
        rsp_data_q <= 32'h0;
      end else if (gnt_vld) begin
        last_q <= sel;
        if (is_part) begin
          state_q    <= RMW_WR;
          rmw_addr_q <= g.addr;
          rmw_word_q <= merged;
          rmw_port_q <= sel;
        end else begin
          rsp_vld_q  <= 1'b1;
          rsp_port_q <= sel;
          rsp_data_q <= is_load ? ram_rdata_i : 32'h0;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    dmem_port_rsp #(.PORT_ID(1'(p))) u_rsp (
      .rsp_vld  (rsp_vld_q),
      .rsp_port (rsp_port_q),
      .rsp_data (rsp_data_q),
      .rvalid   (rvalid[p]),
      .rdata    (rdata[p])
    );
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_rdata_o  = rdata[0];
  assign m1_rdata_o  = rdata[1];
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural RAM; a second,
// fixed-priority instance shares the stimulus for the priority check.

module tb_dmem_port_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_init = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we, busy;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        f0_gnt, f0_rvalid, f1_gnt, f1_rvalid, f_ce, f_we, f_busy;
  logic [31:0] f0_rdata, f1_rdata, f_addr, f_wdata;
  logic [3:0]  f_sel;
  logic [31:0] zero_word = 32'h0;
  logic [31:0] mem [0:63];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  assign ram_rdata = mem[ram_addr[7:2]];

  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | i;
      mem[2] <= 32'h1122_3344;
      mem[4] <= 32'hDEAD_BEEF;
    end else if (ram_ce && ram_we && ram_sel == 4'hf) begin
      mem[ram_addr[7:2]] <= ram_wdata;
    end
  end

  dmem_port_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_sel_o(ram_sel), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .busy_o(busy)
  );

  dmem_port_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b1)) dut_fix (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(f0_gnt), .m0_rvalid_o(f0_rvalid), .m0_rdata_o(f0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(f1_gnt), .m1_rvalid_o(f1_rvalid), .m1_rdata_o(f1_rdata),
    .ram_ce_o(f_ce), .ram_we_o(f_we), .ram_sel_o(f_sel), .ram_addr_o(f_addr),
    .ram_wdata_o(f_wdata), .ram_rdata_i(zero_word), .busy_o(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_be = b; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_be = b; m1_addr = a; m1_wdata = d;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    set_m1(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    step();
    step();
    chk("rst_gnt0", {31'b0, m0_gnt}, 32'd0);
    chk("rst_gnt1", {31'b0, m1_gnt}, 32'd0);
    chk("rst_ce", {31'b0, ram_ce}, 32'd0);
    chk("rst_sel", {28'b0, ram_sel}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_fix_gnt", {30'b0, f1_gnt, f0_gnt}, 32'd0);
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst_ni   = 1'b1;
    mem_init = 1'b0;
  endtask

  initial begin
    do_reset();

    // Load from word 4
    set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    #1;
    chk("ld_gnt0", {31'b0, m0_gnt}, 32'd1);
    chk("ld_addr", ram_addr, 32'h10);
    chk("ld_cewe", {30'b0, ram_ce, ram_we}, 32'd2);
    chk("ld_sel", {28'b0, ram_sel}, 32'hf);
    step();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("ld_rvalid0", {31'b0, m0_rvalid}, 32'd1);
    chk("ld_rdata0", m0_rdata, 32'hDEAD_BEEF);
    chk("ld_rvalid1", {31'b0, m1_rvalid}, 32'd0);

    // Partial store from m1, then load of the same word through a misaligned address
    set_m1(1'b1, 1'b1, 4'b0101, 32'h8, 32'hAABB_CCDD);
    #1;
    chk("ps_gnt1", {31'b0, m1_gnt}, 32'd1);
    chk("ps_rd_cewe", {30'b0, ram_ce, ram_we}, 32'd2);
    step();
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("ps_busy", {31'b0, busy}, 32'd1);
    chk("ps_wr_cewe", {30'b0, ram_ce, ram_we}, 32'd3);
    chk("ps_wr_addr", ram_addr, 32'h8);
    chk("ps_wr_data", ram_wdata, 32'h11BB_33DD);
    chk("ps_no_rvalid", {31'b0, m1_rvalid}, 32'd0);
    step();
    chk("ps_rvalid1", {31'b0, m1_rvalid}, 32'd1);
    chk("ps_rdata1", m1_rdata, 32'h0);
    chk("ps_busy_off", {31'b0, busy}, 32'd0);
    set_m0(1'b1, 1'b0, 4'h0, 32'h0B, 32'h0);
    #1;
    chk("rap_gnt0", {31'b0, m0_gnt}, 32'd1);
    chk("rap_addr", ram_addr, 32'h8);
    step();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rap_rdata0", m0_rdata, 32'h11BB_33DD);

    // Round-robin from reset; fixed-priority instance keeps granting m0
    do_reset();
    set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    set_m1(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_gnt0_%0d", k), {31'b0, m0_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_gnt1_%0d", k), {31'b0, m1_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("fp_gnt_%0d", k), {30'b0, f1_gnt, f0_gnt}, 32'd1);
      if (k > 0) chk($sformatf("rr_rv0_%0d", k), {31'b0, m0_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
      step();
    end
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rr_last_rv1", {31'b0, m1_rvalid}, 32'd1);
    chk("rr_last_rd1", m1_rdata, 32'h11BB_33DD);

    // Contention: m0 partial store wins, m1 held off through RMW_WR
    set_m0(1'b1, 1'b1, 4'b1000, 32'h14, 32'h7700_0000);
    set_m1(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    #1;
    chk("ct_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
    step();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("ct_hold_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    chk("ct_busy", {31'b0, busy}, 32'd1);
    chk("ct_wdata", ram_wdata, 32'h7700_0005);
    step();
    chk("ct_gnt1", {31'b0, m1_gnt}, 32'd1);
    chk("ct_rvalid0", {31'b0, m0_rvalid}, 32'd1);
    step();
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("ct_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd2);
    chk("ct_rdata1", m1_rdata, 32'h7700_0005);

    // Null store then full store with back-to-back load
    set_m1(1'b1, 1'b1, 4'h0, 32'h10, 32'h1234_5678);
    #1;
    chk("ns_gnt1", {31'b0, m1_gnt}, 32'd1);
    chk("ns_ce", {27'b0, ram_sel, ram_ce}, 32'd0);
    step();
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("ns_rvalid1", {31'b0, m1_rvalid}, 32'd1);
    chk("ns_rdata1", m1_rdata, 32'h0);
    chk("ns_mem", mem[4], 32'hDEAD_BEEF);
    set_m0(1'b1, 1'b1, 4'hf, 32'h18, 32'h0102_0304);
    #1;
    chk("fs_gnt0", {31'b0, m0_gnt}, 32'd1);
    chk("fs_cewe", {30'b0, ram_ce, ram_we}, 32'd3);
    chk("fs_wdata", ram_wdata, 32'h0102_0304);
    step();
    set_m0(1'b1, 1'b0, 4'h0, 32'h18, 32'h0);
    chk("fs_rvalid0", {31'b0, m0_rvalid}, 32'd1);
    chk("fs_rdata0", m0_rdata, 32'h0);
    #1;
    chk("b2b_gnt0", {31'b0, m0_gnt}, 32'd1);
    step();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("b2b_rdata0", m0_rdata, 32'h0102_0304);

    // Reset asserted during RMW_WR drops the write and the response
    set_m0(1'b1, 1'b1, 4'b0001, 32'h1C, 32'h0000_00FF);
    #1;
    chk("rr_gnt0", {31'b0, m0_gnt}, 32'd1);
    step();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rr_busy", {31'b0, busy}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rr_outs", {25'b0, busy, ram_ce, ram_we, ram_sel[0], m0_rvalid, m1_rvalid, m0_gnt}, 32'd0);
    chk("rr_addr", ram_addr, 32'h0);
    chk("rr_wdata", ram_wdata, 32'h0);
    step();
    chk("rr_mem", mem[7], 32'hA000_0007);
    chk("rr_no_rv", {31'b0, m0_rvalid}, 32'd0);
    rst_ni = 1'b1;
    step();
    chk("rr_no_rv2", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
